// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle shared by master and slave sides of the memory endpoint.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 6
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 slave that serialises one burst at a time into single-beat SRAM
// request/grant accesses; reads take a request, a wait cycle and a response cycle.
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  AXI_BUS.Slave                       slave,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                        mem_gnt_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int STRB = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE_RESP, READ, READ_WAIT, READ_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      last_write_q, last_write_d;

  logic [AXI_ADDR_WIDTH-1:0] step, wrap_mask, addr_next;
  logic aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;

  always_comb begin
    step      = AXI_ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << size_q) - AXI_ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_next = addr_q + step;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    rdata_d      = rdata_q;
    last_write_d = last_write_q;
    aw_ready     = 1'b0;
    ar_ready     = 1'b0;
    w_ready      = 1'b0;
    b_valid      = 1'b0;
    r_valid      = 1'b0;
    r_last       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '1;
    case (state_q)
      IDLE: begin
        // Read wins a tie only if the previous grant went to the write side.
        if (slave.ar_valid && (!slave.aw_valid || last_write_q)) begin
          ar_ready     = 1'b1;
          addr_d       = slave.ar_addr;
          len_d        = slave.ar_len;
          size_d       = slave.ar_size;
          burst_d      = slave.ar_burst;
          id_d         = slave.ar_id;
          cnt_d        = 8'd0;
          last_write_d = 1'b0;
          state_d      = READ;
        end else if (slave.aw_valid) begin
          aw_ready     = 1'b1;
          addr_d       = slave.aw_addr;
          len_d        = slave.aw_len;
          size_d       = slave.aw_size;
          burst_d      = slave.aw_burst;
          id_d         = slave.aw_id;
          cnt_d        = 8'd0;
          last_write_d = 1'b1;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        mem_req_o = slave.w_valid;
        mem_we_o  = 1'b1;
        mem_be_o  = slave.w_strb;
        w_ready   = mem_gnt_i;
        if (slave.w_valid && mem_gnt_i) begin
          addr_d = addr_next;
          cnt_d  = cnt_q + 8'd1;
          if (slave.w_last) state_d = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        b_valid = 1'b1;
        if (slave.b_ready) state_d = IDLE;
      end
      READ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        rdata_d = mem_rdata_i;
        state_d = READ_RESP;
      end
      READ_RESP: begin
        r_valid = 1'b1;
        r_last  = (cnt_q == len_q);
        if (slave.r_ready) begin
          if (r_last) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_next;
            cnt_d   = cnt_q + 8'd1;
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      rdata_q      <= '0;
      last_write_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      id_q         <= id_d;
      rdata_q      <= rdata_d;
      last_write_q <= last_write_d;
    end
  end

  assign mem_addr_o  = addr_q & ~AXI_ADDR_WIDTH'(STRB - 1);
  assign mem_wdata_o = slave.w_data;

  assign slave.aw_ready = aw_ready;
  assign slave.ar_ready = ar_ready;
  assign slave.w_ready  = w_ready;
  assign slave.b_valid  = b_valid;
  assign slave.b_id     = id_q;
  assign slave.b_resp   = 2'b00;
  assign slave.b_user   = '0;
  assign slave.r_valid  = r_valid;
  assign slave.r_id     = id_q;
  assign slave.r_data   = rdata_q;
  assign slave.r_resp   = 2'b00;
  assign slave.r_last   = r_last;
  assign slave.r_user   = '0;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with a byte-enabled SRAM model and access log.
module tb_axi_mem_slave;
  logic        clk, rst_n;
  logic        mem_req, mem_we, mem_gnt, gnt_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } acc_t;
  acc_t        log_q[$];
  logic [63:0] mem [256];

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6)) axi ();

  axi_mem_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave(axi),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_gnt_i(mem_gnt), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign mem_gnt = gnt_en;

  always @(posedge clk) begin : sram_model
    acc_t e;
    if (mem_req && mem_gnt) begin
      e.we = mem_we; e.addr = mem_addr; e.be = mem_be; e.wdata = mem_wdata;
      log_q.push_back(e);
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) mem[mem_addr[10:3]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[10:3]];
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [9:0] id);
    int n = 0;
    axi.aw_addr = a; axi.aw_len = l; axi.aw_size = s; axi.aw_burst = bt; axi.aw_id = id;
    axi.aw_valid = 1'b1;
    #1;
    while (!axi.aw_ready && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (axi.aw_ready !== 1'b1) begin
      tests_failed++; $display("FAIL aw_handshake: aw_ready=%b required 1", axi.aw_ready);
    end
    @(negedge clk);
    axi.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [9:0] id);
    int n = 0;
    axi.ar_addr = a; axi.ar_len = l; axi.ar_size = s; axi.ar_burst = bt; axi.ar_id = id;
    axi.ar_valid = 1'b1;
    #1;
    while (!axi.ar_ready && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (axi.ar_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ar_handshake: ar_ready=%b required 1", axi.ar_ready);
    end
    @(negedge clk);
    axi.ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last, output int n);
    n = 0;
    axi.w_data = d; axi.w_strb = strb; axi.w_last = last; axi.w_valid = 1'b1;
    #1;
    while (!axi.w_ready && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (axi.w_ready !== 1'b1) begin
      tests_failed++; $display("FAIL w_handshake: w_ready=%b required 1", axi.w_ready);
    end
    @(negedge clk);
    if (last) axi.w_valid = 1'b0;
  endtask

  task automatic recv_r(output logic [63:0] d, output logic [9:0] id, output logic last,
                        output logic [1:0] resp, output int n);
    n = 0;
    #1;
    while (!axi.r_valid && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (axi.r_valid !== 1'b1) begin
      tests_failed++; $display("FAIL r_timeout: r_valid=%b required 1", axi.r_valid);
    end
    d = axi.r_data; id = axi.r_id; last = axi.r_last; resp = axi.r_resp;
    @(negedge clk);
  endtask

  task automatic recv_b(output logic [9:0] id, output logic [1:0] resp, output int n);
    n = 0;
    #1;
    while (!axi.b_valid && n < 20) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (axi.b_valid !== 1'b1) begin
      tests_failed++; $display("FAIL b_timeout: b_valid=%b required 1", axi.b_valid);
    end
    id = axi.b_id; resp = axi.b_resp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0;
    @(negedge clk); #1;
    obs = {axi.aw_ready, axi.ar_ready, axi.w_ready, axi.b_valid, axi.r_valid, mem_req, mem_we,
           axi.r_last, |axi.r_data, |axi.r_id, |axi.b_id};
    tests_run++;
    if (obs !== 11'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b required 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [9:0] id; logic [1:0] resp; int n;
    log_q.delete();
    send_aw(32'h100, 8'd0, 3'd3, 2'b01, 10'h2A);
    send_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, n);
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("FAIL wr_first_beat_wait: got %0d required 0", n); end
    recv_b(id, resp, n);
    tests_run++;
    if (n !== 0) begin tests_failed++; $display("FAIL b_latency: got %0d required 0", n); end
    tests_run++;
    if (id !== 10'h2A || resp !== 2'b00) begin
      tests_failed++; $display("FAIL wr_b: id=%h resp=%b required 02a/00", id, resp);
    end
    tests_run++;
    if (log_q.size() !== 1) begin
      tests_failed++; $display("FAIL wr_count: got %0d required 1", log_q.size());
    end else begin
      tests_run++;
      if (log_q[0] !== {1'b1, 32'h100, 8'hFF, 64'hDEADBEEF_CAFEF00D}) begin
        tests_failed++; $display("FAIL wr_access: got %h required 1_00000100_ff_deadbeefcafef00d", log_q[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_rd = 3'b101;
    logic [63:0] d; logic [9:0] id; logic last; logic [1:0] resp; int n;
    for (int t = 0; t < 3; t++) begin
      axi.ar_addr = (t == 0) ? 32'h208 : 32'h210; axi.ar_len = 8'd0; axi.ar_size = 3'd3;
      axi.ar_burst = 2'b01; axi.ar_id = 10'h60 + 10'(t); axi.ar_valid = 1'b1;
      axi.aw_addr = 32'h180; axi.aw_len = 8'd0; axi.aw_size = 3'd3;
      axi.aw_burst = 2'b01; axi.aw_id = 10'h70 + 10'(t); axi.aw_valid = 1'b1;
      #1;
      tests_run++;
      if (axi.ar_ready !== exp_rd[t] || axi.aw_ready !== !exp_rd[t]) begin
        tests_failed++;
        $display("FAIL arb_%0d: ar_ready=%b aw_ready=%b required %b/%b", t, axi.ar_ready, axi.aw_ready,
                 exp_rd[t], !exp_rd[t]);
      end
      @(negedge clk);
      axi.ar_valid = 1'b0; axi.aw_valid = 1'b0;
      if (exp_rd[t]) begin
        recv_r(d, id, last, resp, n);
        tests_run++;
        if (d !== ((t == 0) ? 64'hF00D0041_00000208 : 64'hF00D0042_00000210) || id !== 10'h60 + 10'(t) || last !== 1'b1) begin
          tests_failed++; $display("FAIL arb_rd_%0d: data=%h id=%h last=%b", t, d, id, last);
        end
      end else begin
        send_w(64'h01234567_89ABCDEF, 8'hFF, 1'b1, n);
        recv_b(id, resp, n);
        tests_run++;
        if (id !== 10'h71) begin tests_failed++; $display("FAIL arb_wr_id: got %h required 071", id); end
      end
    end
  endtask

  task automatic test_read_burst(input logic [31:0] a, input logic [1:0] bt, input logic [9:0] rid,
                                 input logic [31:0] ea [4], input logic [63:0] ed [4]);
    logic [63:0] d; logic [9:0] id; logic last; logic [1:0] resp; int n;
    log_q.delete();
    send_ar(a, 8'd3, 3'd3, bt, rid);
    for (int i = 0; i < 4; i++) begin
      recv_r(d, id, last, resp, n);
      tests_run++;
      if (d !== ed[i] || id !== rid || last !== (i == 3) || resp !== 2'b00 || n !== 2) begin
        tests_failed++;
        $display("FAIL rd_beat_%0d: data=%h id=%h last=%b resp=%b wait=%0d required %h/%h/%b/00/2",
                 i, d, id, last, resp, n, ed[i], rid, (i == 3));
      end
    end
    tests_run++;
    if (log_q.size() !== 4) begin
      tests_failed++; $display("FAIL rd_count: got %0d required 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (log_q[i].addr !== ea[i] || log_q[i].we !== 1'b0 || log_q[i].be !== 8'hFF) begin
          tests_failed++;
          $display("FAIL rd_addr_%0d: got %h we=%b be=%h required %h/0/ff", i, log_q[i].addr, log_q[i].we,
                   log_q[i].be, ea[i]);
        end
      end
    end
  endtask

  task automatic test_incr_read();
    logic [31:0] ea [4] = '{32'h200, 32'h208, 32'h210, 32'h218};
    logic [63:0] ed [4] = '{64'hF00D0040_00000200, 64'hF00D0041_00000208,
                            64'hF00D0042_00000210, 64'hF00D0043_00000218};
    test_read_burst(32'h200, 2'b01, 10'h11, ea, ed);
  endtask

  task automatic test_wrap_read();
    logic [31:0] ea [4] = '{32'h118, 32'h100, 32'h108, 32'h110};
    logic [63:0] ed [4] = '{64'hF00D0023_00000118, 64'hDEADBEEF_CAFEF00D,
                            64'hF00D0021_00000108, 64'hF00D0022_00000110};
    test_read_burst(32'h118, 2'b10, 10'h05, ea, ed);
  endtask

  task automatic test_narrow_write();
    logic [9:0] id; logic [1:0] resp; int n;
    log_q.delete();
    send_aw(32'h103, 8'd0, 3'd0, 2'b01, 10'h07);
    send_w(64'h00000000_AB000000, 8'h08, 1'b1, n);
    recv_b(id, resp, n);
    tests_run++;
    if (log_q.size() !== 1 || log_q[0].addr !== 32'h100 || log_q[0].be !== 8'h08) begin
      tests_failed++; $display("FAIL narrow_access: n=%0d addr=%h be=%h required 1/100/08",
                               log_q.size(), mem_addr, mem_be);
    end
    tests_run++;
    if (mem[8'h20] !== 64'hDEADBEEF_ABFEF00D) begin
      tests_failed++; $display("FAIL narrow_merge: got %h required deadbeefabfef00d", mem[8'h20]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] wd [4] = '{64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001,
                            64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003};
    logic [63:0] d; logic [9:0] id; logic last; logic [1:0] resp; int n;
    log_q.delete();
    send_aw(32'h300, 8'd3, 3'd3, 2'b01, 10'h33);
    send_w(wd[0], 8'hFF, 1'b0, n);
    gnt_en = 1'b0;
    axi.w_data = wd[1]; axi.w_last = 1'b0; axi.w_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (axi.w_ready !== 1'b0) begin tests_failed++; $display("FAIL w_ready_no_gnt_%0d: got %b required 0", c, axi.w_ready); end
      @(negedge clk);
    end
    gnt_en = 1'b1;
    send_w(wd[1], 8'hFF, 1'b0, n);
    axi.b_ready = 1'b0;
    send_w(wd[2], 8'hFF, 1'b0, n);
    send_w(wd[3], 8'hFF, 1'b1, n);
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (axi.b_valid !== 1'b1 || axi.b_id !== 10'h33 || axi.b_resp !== 2'b00) begin
        tests_failed++; $display("FAIL b_hold_%0d: valid=%b id=%h resp=%b required 1/033/00", c, axi.b_valid, axi.b_id, axi.b_resp);
      end
      @(negedge clk);
    end
    axi.b_ready = 1'b1;
    recv_b(id, resp, n);
    tests_run++;
    if (id !== 10'h33) begin tests_failed++; $display("FAIL bp_b_id: got %h required 033", id); end
    tests_run++;
    if (log_q.size() !== 4) begin
      tests_failed++; $display("FAIL bp_wr_count: got %0d required 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (log_q[i].addr !== 32'h300 + 32'(i * 8) || log_q[i].wdata !== wd[i]) begin
          tests_failed++; $display("FAIL bp_wr_%0d: addr=%h data=%h required %h/%h", i, log_q[i].addr, log_q[i].wdata, 32'h300 + 32'(i * 8), wd[i]);
        end
      end
    end
    axi.r_ready = 1'b0;
    send_ar(32'h300, 8'd1, 3'd3, 2'b01, 10'h44);
    n = 0;
    #1;
    while (!axi.r_valid && n < 20) begin @(negedge clk); #1; n++; end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (axi.r_valid !== 1'b1 || axi.r_data !== wd[0] || axi.r_id !== 10'h44 || axi.r_last !== 1'b0) begin
        tests_failed++; $display("FAIL r_hold_%0d: valid=%b data=%h id=%h last=%b required 1/%h/044/0", c, axi.r_valid, axi.r_data, axi.r_id, axi.r_last, wd[0]);
      end
      @(negedge clk); #1;
    end
    axi.r_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      recv_r(d, id, last, resp, n);
      tests_run++;
      if (d !== wd[i] || last !== (i == 1)) begin
        tests_failed++; $display("FAIL bp_rd_%0d: data=%h last=%b required %h/%b", i, d, last, wd[i], (i == 1));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] d; logic [9:0] id; logic last; logic [1:0] resp; int n;
    logic [8:0] obs;
    send_ar(32'h400, 8'd7, 3'd3, 2'b01, 10'h5A);
    recv_r(d, id, last, resp, n);
    recv_r(d, id, last, resp, n);
    tests_run++;
    if (d !== 64'hF00D0081_00000408) begin tests_failed++; $display("FAIL pre_reset_beat: got %h required f00d008100000408", d); end
    n = 0;
    #1;
    while (!axi.r_valid && n < 20) begin @(negedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    obs = {axi.r_valid, axi.r_last, |axi.r_data, |axi.r_id, mem_req, mem_we, axi.ar_ready,
           axi.aw_ready, axi.b_valid};
    tests_run++;
    if (obs !== 9'b0) begin tests_failed++; $display("FAIL async_reset: got %b required 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_ar(32'h408, 8'd1, 3'd3, 2'b01, 10'h0C);
    for (int i = 0; i < 2; i++) begin
      recv_r(d, id, last, resp, n);
      tests_run++;
      if (d !== ((i == 0) ? 64'hF00D0081_00000408 : 64'hF00D0082_00000410) || id !== 10'h0C || last !== (i == 1)) begin
        tests_failed++; $display("FAIL post_reset_rd_%0d: data=%h id=%h last=%b", i, d, id, last);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = {32'hF00D0000 + 32'(k), 32'(k * 8)};
    rst_n = 1'b0; gnt_en = 1'b1;
    axi.aw_valid = 1'b0; axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0;
    axi.aw_burst = '0; axi.aw_lock = 1'b0; axi.aw_cache = '0; axi.aw_prot = '0; axi.aw_qos = '0;
    axi.aw_region = '0; axi.aw_user = '0;
    axi.ar_valid = 1'b0; axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0;
    axi.ar_burst = '0; axi.ar_lock = 1'b0; axi.ar_cache = '0; axi.ar_prot = '0; axi.ar_qos = '0;
    axi.ar_region = '0; axi.ar_user = '0;
    axi.w_valid = 1'b0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0; axi.w_user = '0;
    axi.b_ready = 1'b1; axi.r_ready = 1'b1;
    test_reset();
    test_single_write();
    test_simultaneous();
    test_incr_read();
    test_wrap_read();
    test_narrow_write();
    test_backpressure();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 slave endpoint that terminates one `AXI_BUS.Slave` port and converts its read and write bursts into single-beat requests on a simple single-port SRAM request/grant interface. It sits directly downstream of the AXI interconnect, in front of on-chip data/instruction RAM. It supports all AXI4 burst types and processes one transaction at a time, with no outstanding transactions.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 32: address width of the bus and of `mem_addr_o`.
- `AXI_DATA_WIDTH`, 64: data width of the bus and memory. `STRB = AXI_DATA_WIDTH/8`.
- `AXI_ID_WIDTH`, 10: transaction ID width.
- `AXI_USER_WIDTH`, 6: user signal width.

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `slave`  `AXI_BUS.Slave`  n/a  AXI4 slave port, with parameters matching the above.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  `AXI_ADDR_WIDTH`  byte address, with the low `log2(STRB)` bits forced to 0.
- `mem_wdata_o`  out  `AXI_DATA_WIDTH`  write data.
- `mem_be_o`  out  `STRB`  byte enables.
- `mem_gnt_i`  in  1  request accepted in this cycle.
- `mem_rdata_i`  in  `AXI_DATA_WIDTH`  read data, valid exactly one cycle after a granted read.

## Operation
- **States:** IDLE, WRITE, WRITE_RESP, READ, READ_WAIT, READ_RESP.
- **IDLE:**
  - If only `ar_valid` is high, assert `ar_ready` and go to READ.
  - If only `aw_valid` is high, assert `aw_ready` and go to WRITE.
  - If both are high, round-robin: the channel not served last wins. After reset, read wins.
  - The handshake latches addr, len, size, burst and id, and clears the beat counter.
- **WRITE:**
  - `mem_req_o = w_valid`, `mem_we_o = 1`, `mem_wdata_o = w_data`, `mem_be_o = w_strb`.
  - `w_ready = mem_gnt_i`.
  - Each accepted beat advances the address and the beat counter.
  - The beat with `w_last` goes to WRITE_RESP. `w_last` alone terminates the burst; `aw_len` is not checked against it.
- **WRITE_RESP:** `b_valid = 1`, `b_resp = OKAY`, `b_id` = latched id, `b_user = 0`. When `b_ready` is high, go to IDLE.
- **READ:** `mem_req_o = 1`, `mem_we_o = 0`, `mem_be_o` = all ones. When `mem_gnt_i` is high, go to READ_WAIT.
- **READ_WAIT:** capture `mem_rdata_i` into the `r_data` register and go to READ_RESP.
- **READ_RESP:**
  - `r_valid = 1`, `r_resp = OKAY`, `r_id` = latched id, `r_user = 0`.
  - `r_last = (beat counter == latched len)`.
  - When `r_ready` is high: on the last beat go to IDLE; otherwise advance the address and counter and go to READ.
- **Address update** (step = `1 << size`):
  - FIXED: unchanged.
  - INCR: addr + step.
  - WRAP: bound = (len+1) << size; next = (addr & ~(bound−1)) | ((addr+step) & (bound−1)).
  - Reserved burst type 2'b11 is treated as INCR.
- **Width rules:**
  - The beat counter is 8 bits and compares against `len`.
  - Address arithmetic is `AXI_ADDR_WIDTH` wide and wraps modulo 2^`AXI_ADDR_WIDTH`.
  - `size > log2(STRB)` is outside the contract.
- **Ignored inputs:** prot, region, lock, cache, qos, aw_user, ar_user, w_user.
- **Per-state handshake outputs:** `aw_ready`, `ar_ready`, `w_ready`, `b_valid` and `r_valid` are 0 outside the states above.
  - In particular, W beats presented while in IDLE are not accepted.

## Timing
- **Reset values:** state IDLE; every ready/valid output 0; `mem_req_o` 0; `mem_we_o` 0; last-served flag = write.
  - Registered `r_data`, `b_id`, `r_id` = 0; `r_last` 0.
  - Asserting reset mid-burst aborts immediately with no response; the master must also be reset.
- **AW/AR ready:** `aw_ready`/`ar_ready` are combinational from valid plus arbitration in IDLE. The handshake is at cycle 0; the first `mem_req_o` is at cycle 1.
- **Write throughput:** 1 beat/cycle when `w_valid` and `mem_gnt_i` are held high. `b_valid` rises the cycle after the `w_last` handshake.
- **Read latency:** with `gnt` immediate and `r_ready` high, the first `r_valid` is at cycle 3 after the AR handshake, then one beat every 3 cycles.
- **Valid stability:** `r_valid`/`b_valid` and their payloads are held stable until the matching ready.
- **Combinational path:** `mem_gnt_i` → `w_ready` is the only combinational path from the memory side to AXI.

## Test plan
- **Single write:**
  - Stimulus: AW addr 0x100, len 0, size 3, id 0x2A; W data 0xDEADBEEF_CAFEF00D, strb 0xFF, last.
  - Response: one mem write at 0x100 with be 0xFF; then B OKAY, id 0x2A.
- **INCR read:**
  - Stimulus: AR addr 0x200, len 3, size 3, on a preloaded memory.
  - Response: mem reads at 0x200, 0x208, 0x210, 0x218; four R beats with `r_last` only on beat 3.
- **WRAP read:**
  - Stimulus: AR addr 0x118, len 3, size 3.
  - Response: addresses 0x118, 0x100, 0x108, 0x110.
- **Backpressure:**
  - Stimulus: `mem_gnt_i` low for 5 cycles during a write burst; `r_ready`/`b_ready` low for 4 cycles.
  - Response: `w_ready` stays 0 while `mem_gnt_i` is low. `r_valid`/`b_valid`, `r_data`/`r_id`/`r_last` and `b_id`/`b_resp` stay stable while ready is low. No beat is lost or duplicated.
- **Simultaneous AW/AR:**
  - Stimulus: AW and AR valid together, three times.
  - Response: the first is served as read, then write, then read.
  - Stimulus: narrow write, size 0, addr 0x103, strb 0x08.
  - Response: `mem_addr_o` 0x100, `mem_be_o` 0x08.
- **Reset mid-burst:**
  - Stimulus: assert `rst_ni` low during beat 2 of a len 7 read.
  - Response: all outputs return to their reset values asynchronously. A new AR accepted after reset is served correctly from its first beat.
